hssi_rst_seq: RTL and testbench

// - Serialising reset scheduler for NUM_CH HSSI channel reset controllers that use an ack handshake.
// - Collects per-channel reset requests and grants them one channel at a time, in round-robin order.
// - For each granted channel: assert reset, wait for ack, hold, release, wait for ack to drop.
// - Sits between subsystem CSR/soft-reset sources and the per-channel reset/ack pairs.
// - At power-up, sequences every channel automatically.

---
 rtl/hssi_rst_seq.sv | 105 ++++++++++
 tb/tb_hssi_rst_seq.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/hssi_rst_seq.sv
// hssi_rst_seq: round-robin serialiser of per-channel reset/ack handshakes.
// One channel at a time: assert, wait ack, hold, release, wait ack low.
module hssi_rst_seq #(
   parameter int NUM_CH   = 4,
   parameter int MIN_HOLD = 16,
   parameter int TIMEOUT  = 4096
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic [NUM_CH-1:0] i_req,
   input  logic [NUM_CH-1:0] i_ack,
   output logic [NUM_CH-1:0] o_rst,
   output logic [NUM_CH-1:0] o_done,
   output logic [NUM_CH-1:0] o_timeout,
   output logic              o_busy
);
   localparam int PW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] TMO_LAST  = CW'(TIMEOUT - 1);
   localparam logic [CW-1:0] HOLD_LAST = CW'(MIN_HOLD > 0 ? MIN_HOLD - 1 : 0);
   typedef enum logic [2:0] {IDLE, ASSERT, HOLD, RELEASE, ABORT} state_t;
   state_t            state_q, state_d;
   logic [PW-1:0]     ptr_q, ptr_d, gnt_q, gnt_d, sel;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [NUM_CH-1:0] pend_q, pend_d, rst_q, rst_d, done_q, done_d, tmo_q, tmo_d;
   logic              ack;
   // first pending channel at or after the pointer, wrapping
   function automatic logic [PW-1:0] pick(input logic [NUM_CH-1:0] p, input logic [PW-1:0] s);
      logic [PW-1:0] j;
      pick = s;
      for (int k = NUM_CH - 1; k >= 0; k--) begin
         j = PW'((int'(s) + k) % NUM_CH);
         if (p[j]) pick = j;
      end
   endfunction
   assign sel = pick(pend_q, ptr_q);
   assign ack = i_ack[gnt_q];
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      gnt_d   = gnt_q;
      rst_d   = rst_q;
      done_d  = '0;
      pend_d  = pend_q | i_req;
      tmo_d   = tmo_q & ~i_req;
      unique case (state_q)
         IDLE: if (|pend_q) begin
            state_d = ASSERT;
            gnt_d   = sel;
            ptr_d   = sel == PW'(NUM_CH - 1) ? '0 : sel + 1'b1;
            rst_d   = NUM_CH'(1) << sel;
            pend_d  = (pend_q & ~(NUM_CH'(1) << sel)) | i_req;
         end
         ASSERT: if (ack) begin
            state_d = MIN_HOLD == 0 ? RELEASE : HOLD;
            rst_d   = MIN_HOLD == 0 ? '0 : rst_q;
         end else if (cnt_q == TMO_LAST) begin
            state_d = ABORT;
            rst_d   = '0;
         end
         HOLD: if (cnt_q == HOLD_LAST) begin
            state_d = RELEASE;
            rst_d   = '0;
         end
         RELEASE: if (!ack) begin
            state_d = IDLE;
            done_d  = NUM_CH'(1) << gnt_q;
         end else if (cnt_q == TMO_LAST) begin
            state_d = ABORT;
         end
         ABORT: begin
            state_d = IDLE;
            rst_d   = '0;
            tmo_d   = (tmo_q | (NUM_CH'(1) << gnt_q)) & ~i_req;
         end
         default: state_d = IDLE;
      endcase
      cnt_d = state_d != state_q ? '0 : (&cnt_q ? cnt_q : cnt_q + 1'b1);
   end
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         gnt_q   <= '0;
         cnt_q   <= '0;
         pend_q  <= '1;
         rst_q   <= '0;
         done_q  <= '0;
         tmo_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         gnt_q   <= gnt_d;
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
         rst_q   <= rst_d;
         done_q  <= done_d;
         tmo_q   <= tmo_d;
      end
   end
   assign o_rst     = rst_q;
   assign o_done    = done_q;
   assign o_timeout = tmo_q;
   assign o_busy    = state_q != IDLE;
endmodule

// File: tb/tb_hssi_rst_seq.sv
// tb_hssi_rst_seq: scoreboard bench; expected grant/done/timeout events are queued
// by the stimulus and popped by a monitor as the DUT produces them.
module tb_hssi_rst_seq;
   localparam int GNT = 0, DONE = 1, TMO = 2;
   typedef struct {int kind; int ch; int dur;} ev_t;
   logic       clk = 1'b0;
   logic       i_rst = 1'b1;
   logic [3:0] i_req = '0;
   logic [3:0] ack;
   logic [3:0] o_rst, o_done, o_timeout;
   logic       o_busy;
   int         errs = 0, checks = 0;
   ev_t        q[$];
   int         dly[4] = '{3, 3, 3, 3};
   int         mode[4] = '{0, 0, 0, 0};
   logic [7:0] hist[4] = '{default: 8'h00};
   logic [3:0] prst = '0, ptmo = '0;
   int         hi[4] = '{0, 0, 0, 0};
   int         dur[4] = '{0, 0, 0, 0};

   always #5 clk = ~clk;

   hssi_rst_seq #(.NUM_CH(4), .MIN_HOLD(16), .TIMEOUT(64)) dut (
      .i_clk(clk), .i_rst(i_rst), .i_req(i_req), .i_ack(ack),
      .o_rst(o_rst), .o_done(o_done), .o_timeout(o_timeout), .o_busy(o_busy));

   // ack model: mode 0 follows o_rst delayed dly cycles, 1 stuck low, 2 stuck high
   always @(posedge clk) for (int i = 0; i < 4; i++) hist[i] <= {hist[i][6:0], o_rst[i]};
   always_comb begin
      ack = '0;
      for (int i = 0; i < 4; i++)
         ack[i] = mode[i] == 1 ? 1'b0 : mode[i] == 2 ? 1'b1 : hist[i][dly[i]-1];
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic expect_ev(input int kind, input int ch, input int d);
      q.push_back('{kind, ch, d});
   endtask

   task automatic got(input int kind, input int ch, input int d);
      ev_t e;
      if (q.size() == 0) begin
         checks++;
         errs++;
         $display("FAIL unexpected_event: got kind=%0d ch=%0d dur=%0d expected none", kind, ch, d);
      end else begin
         e = q.pop_front();
         chk("ev_kind", kind, e.kind);
         chk("ev_ch", ch, e.ch);
         chk("ev_dur", d, e.dur);
         chk("rst_onehot", int'($onehot0(o_rst)), 1);
      end
   endtask

   always @(negedge clk) begin
      if (!i_rst) begin
         for (int i = 0; i < 4; i++) begin
            if (o_rst[i] && !prst[i]) begin
               hi[i] = 0;
               got(GNT, i, 0);
            end
            if (o_rst[i]) hi[i]++;
            else if (prst[i]) dur[i] = hi[i];
            if (o_done[i]) got(DONE, i, dur[i]);
            if (o_timeout[i] && !ptmo[i]) got(TMO, i, dur[i]);
         end
      end
      prst = o_rst;
      ptmo = o_timeout;
   end

   task automatic pulse_req(input logic [3:0] v);
      i_req = v;
      @(negedge clk);
      i_req = '0;
   endtask

   task automatic wait_idle(input string name, input int budget);
      int n = 0;
      while ((q.size() != 0 || o_busy) && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk({name, "_idle"}, int'(q.size() == 0 && !o_busy), 1);
   endtask

   task automatic wait_rst(input int ch, input int budget);
      int n = 0;
      while (!o_rst[ch] && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk("wait_rst", int'(o_rst[ch]), 1);
   endtask

   initial begin
      repeat (5) @(negedge clk);
      chk("reset_rst", o_rst, 0);
      chk("reset_done", o_done, 0);
      chk("reset_tmo", o_timeout, 0);
      chk("reset_busy", o_busy, 0);
      for (int i = 0; i < 4; i++) begin
         expect_ev(GNT, i, 0);
         expect_ev(DONE, i, 20);
      end
      i_rst = 1'b0;
      wait_idle("powerup", 2000);
      expect_ev(GNT, 1, 0);
      expect_ev(DONE, 1, 20);
      expect_ev(GNT, 3, 0);
      pulse_req(4'b1010);
      wait_rst(3, 500);
      pulse_req(4'b0010);
      expect_ev(DONE, 3, 20);
      expect_ev(GNT, 1, 0);
      expect_ev(DONE, 1, 20);
      wait_idle("round_robin", 1000);
      dly[2] = 5;
      expect_ev(GNT, 2, 0);
      expect_ev(DONE, 2, 22);
      pulse_req(4'b0100);
      wait_idle("hold", 500);
      mode[1] = 1;
      expect_ev(GNT, 1, 0);
      expect_ev(TMO, 1, 64);
      expect_ev(GNT, 2, 0);
      expect_ev(DONE, 2, 22);
      pulse_req(4'b0110);
      wait_idle("tmo_assert", 1000);
      mode[1] = 0;
      chk("tmo_sticky", o_timeout, 4'b0010);
      expect_ev(GNT, 1, 0);
      expect_ev(DONE, 1, 20);
      i_req = 4'b0010;
      @(negedge clk);
      i_req = '0;
      chk("sticky_clr", o_timeout, 0);
      chk("lat_before", o_rst, 0);
      @(negedge clk);
      chk("lat_after", o_rst, 4'b0010);
      wait_idle("sticky", 500);
      mode[0] = 2;
      expect_ev(GNT, 0, 0);
      expect_ev(TMO, 0, 17);
      pulse_req(4'b0001);
      wait_idle("tmo_release", 1000);
      mode[0] = 0;
      chk("tmo_release_sticky", o_timeout, 4'b0001);
      dly[2] = 3;
      expect_ev(GNT, 2, 0);
      pulse_req(4'b0100);
      wait_rst(2, 100);
      repeat (8) @(negedge clk);
      i_rst = 1'b1;
      @(negedge clk);
      chk("midrst_rst", o_rst, 0);
      chk("midrst_busy", o_busy, 0);
      chk("midrst_tmo", o_timeout, 0);
      for (int i = 0; i < 4; i++) begin
         expect_ev(GNT, i, 0);
         expect_ev(DONE, i, 20);
      end
      i_rst = 1'b0;
      wait_idle("midrst_reseq", 2000);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog expired");
   end
endmodule
